fp8_accumulator: RTL and testbench

FP8_ACCUMULATOR -- requirements
Module: fp8_accumulator

---
 rtl/fp8_accumulator.sv | 169 ++++++++++++++++
 tb/tb_fp8_accumulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_accumulator.sv
// Sums a group of FP8 E4M3 products into one E4M3 result. The sum is kept
// in a 24-bit saturating fixed-point accumulator in units of 2^-9.
module fp8_accumulator (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_nan,
    output logic       out_sat,
    output logic [7:0] out_count
);

    typedef enum logic [1:0] {ACC, NORM, HOLD} state_t;

    localparam logic signed [24:0] SAT_POS = 25'sd8388607;

    state_t             state, state_nxt;
    logic signed [23:0] acc;
    logic [7:0]         count;
    logic               nan, sat;

    // Decode the incoming beat to a signed fixed-point value
    logic [3:0]         in_exp;
    logic [2:0]         in_man;
    logic [22:0]        beat_mag;
    logic signed [24:0] beat_val;
    logic signed [24:0] sum;
    logic signed [23:0] acc_nxt;
    logic               sum_sat;
    logic               beat_nan;

    assign in_exp   = in_data[6:3];
    assign in_man   = in_data[2:0];
    assign beat_nan = (in_data[6:0] == 7'h7F);

    always_comb begin
        beat_mag = 23'd0;
        if (in_exp == 4'd0)
            beat_mag = {20'd0, in_man};
        else
            beat_mag = 23'({1'b1, in_man}) << (in_exp - 4'd1);
    end

    assign beat_val = in_data[7] ? -$signed({2'b00, beat_mag}) : $signed({2'b00, beat_mag});
    assign sum      = $signed({acc[23], acc}) + beat_val;

    always_comb begin
        sum_sat = 1'b0;
        acc_nxt = sum[23:0];
        if (sum > SAT_POS) begin
            sum_sat = 1'b1;
            acc_nxt = SAT_POS[23:0];
        end else if (sum < -SAT_POS) begin
            sum_sat = 1'b1;
            acc_nxt = -SAT_POS[23:0];
        end
    end

    // Encode |acc| back to E4M3, truncating toward zero
    logic [23:0] abs_acc;
    logic [22:0] mag;
    logic [22:0] mag_shift;
    logic [4:0]  lead;
    logic [3:0]  enc_exp;
    logic [2:0]  enc_man;
    logic        enc_sat;
    logic [7:0]  enc_data;

    assign abs_acc = acc[23] ? 24'(-acc) : 24'(acc);
    assign mag     = abs_acc[22:0];

    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 23; i++)
            if (mag[i]) lead = 5'(i);
    end

    always_comb begin
        enc_exp   = 4'd0;
        enc_man   = 3'd0;
        enc_sat   = 1'b0;
        mag_shift = 23'd0;
        if (lead < 5'd3) begin
            enc_man = mag[2:0];
        end else begin
            mag_shift = mag >> (lead - 5'd3);
            enc_man   = mag_shift[2:0];
            enc_exp   = 4'(lead - 5'd2);
            // 0x7F is reserved for NaN, so the top finite code is 448
            if (lead > 5'd17 || (lead == 5'd17 && enc_man == 3'd7)) begin
                enc_sat = 1'b1;
                enc_exp = 4'd15;
                enc_man = 3'd6;
            end
        end
    end

    always_comb begin
        if (nan)
            enc_data = 8'h7F;
        else if (mag == 23'd0)
            enc_data = 8'h00;
        else
            enc_data = {acc[23], enc_exp, enc_man};
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (in_valid && in_last) state_nxt = NORM;
            NORM:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            count     <= '0;
            nan       <= 1'b0;
            sat       <= 1'b0;
            out_data  <= 8'h00;
            out_nan   <= 1'b0;
            out_sat   <= 1'b0;
            out_count <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                ACC: begin
                    if (in_valid) begin
                        if (count != 8'hFF) count <= count + 8'd1;
                        if (beat_nan) begin
                            nan <= 1'b1;
                        end else begin
                            acc <= acc_nxt;
                            if (sum_sat) sat <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    out_data  <= enc_data;
                    out_nan   <= nan;
                    out_sat   <= sat | enc_sat;
                    out_count <= count;
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                        nan   <= 1'b0;
                        sat   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_accumulator.sv
// Directed bench for fp8_accumulator: expected results are queued at issue
// time and a monitor pops them on every output handshake.
module tb_fp8_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data, out_count;
    logic       out_nan, out_sat;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       nan;
        logic       sat;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];

    fp8_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nan(out_nan), .out_sat(out_sat), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: compare every accepted result with the head of the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data",  32'(out_data),  32'(e.data));
                chk("out_nan",   32'(out_nan),   32'(e.nan));
                chk("out_sat",   32'(out_sat),   32'(e.sat));
                chk("out_count", 32'(out_count), 32'(e.count));
            end
        end
    end

    task automatic expect_res(input logic [7:0] d, input logic n, input logic s, input logic [7:0] c);
        exp_q.push_back('{data: d, nan: n, sat: s, count: c});
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("result_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_flags",     32'({out_nan, out_sat}), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1.0 + 2.0 = 3.0, with latency: one cycle in NORM, then HOLD
        expect_res(8'h44, 1'b0, 1'b0, 8'd2);
        send_beat(8'h38, 1'b0);
        send_beat(8'h40, 1'b1);
        chk("lat_norm_valid", 32'(out_valid), 32'd0);
        chk("lat_norm_ready", 32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        chk("lat_hold_valid", 32'(out_valid), 32'd1);
        wait_done();

        // Cancellation to zero, and subnormal addition
        expect_res(8'h00, 1'b0, 1'b0, 8'd2);
        send_beat(8'h38, 1'b0);
        send_beat(8'hB8, 1'b1);
        wait_done();
        expect_res(8'h02, 1'b0, 1'b0, 8'd2);
        send_beat(8'h01, 1'b0);
        send_beat(8'h01, 1'b1);
        wait_done();

        // Truncation toward zero: 1.0 + 2^-9 stays 1.0
        expect_res(8'h38, 1'b0, 1'b0, 8'd2);
        send_beat(8'h38, 1'b0);
        send_beat(8'h01, 1'b1);
        wait_done();

        // Largest finite value alone does not saturate
        expect_res(8'h7E, 1'b0, 1'b0, 8'd1);
        send_beat(8'h7E, 1'b1);
        wait_done();

        // Encoder saturation: 448+448, -448-448, and p=17 with m=7 (240+240)
        expect_res(8'h7E, 1'b0, 1'b1, 8'd2);
        send_beat(8'h7E, 1'b0);
        send_beat(8'h7E, 1'b1);
        wait_done();
        expect_res(8'hFE, 1'b0, 1'b1, 8'd2);
        send_beat(8'hFE, 1'b0);
        send_beat(8'hFE, 1'b1);
        wait_done();
        expect_res(8'h7E, 1'b0, 1'b1, 8'd2);
        send_beat(8'h77, 1'b0);
        send_beat(8'h77, 1'b1);
        wait_done();

        // Accumulator clamp: 40 x 448 exceeds 2^23-1 units
        expect_res(8'h7E, 1'b0, 1'b1, 8'd40);
        for (int i = 0; i < 39; i++) send_beat(8'h7E, 1'b0);
        send_beat(8'h7E, 1'b1);
        wait_done();

        // NaN is sticky and overrides the sum
        expect_res(8'h7F, 1'b1, 1'b0, 8'd2);
        send_beat(8'h7F, 1'b0);
        send_beat(8'h38, 1'b1);
        wait_done();

        // Beat count saturates at 255
        expect_res(8'h00, 1'b0, 1'b0, 8'd255);
        for (int i = 0; i < 299; i++) send_beat(8'h00, 1'b0);
        send_beat(8'h00, 1'b1);
        wait_done();

        // Backpressure: result held, offered beats ignored
        out_ready = 1'b0;
        expect_res(8'h44, 1'b0, 1'b0, 8'd2);
        send_beat(8'h38, 1'b0);
        send_beat(8'h40, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h38;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_data", 32'(out_data),  32'h44);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        expect_res(8'h30, 1'b0, 1'b0, 8'd1);
        send_beat(8'h30, 1'b1);
        wait_done();

        // Reset mid-group discards the partial sum
        send_beat(8'h38, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        expect_res(8'h40, 1'b0, 1'b0, 8'd1);
        send_beat(8'h40, 1'b1);
        wait_done();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
